// File: rtl/shift_arbiter_if.sv
// Bus bundle for shift_arbiter: two requester channels, the shared shifter
// link and status.
//   slave  : arbiter side (requests/operands/sh_result in; acks, dones,
//            res, shifter controls, busy, op_count out)
//   master : environment side (requesters plus the external shifter)
interface shift_arbiter_if #(
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned AMT_W  = 5;

  logic              req0;
  logic              req1;
  logic [DATA_W-1:0] op0;
  logic [DATA_W-1:0] op1;
  logic [AMT_W-1:0]  amt0;
  logic [AMT_W-1:0]  amt1;
  logic              dir0;
  logic              dir1;
  logic              ack0;
  logic              ack1;
  logic              done0;
  logic              done1;
  logic [DATA_W-1:0] res;
  logic [DATA_W-1:0] sh_a;
  logic [AMT_W-1:0]  sh_amt;
  logic              sh_dir;
  logic [DATA_W-1:0] sh_result;
  logic              busy;
  logic [CNT_W-1:0]  op_count;

  modport slave (
    input  req0, req1, op0, op1, amt0, amt1, dir0, dir1, sh_result,
    output ack0, ack1, done0, done1, res, sh_a, sh_amt, sh_dir, busy, op_count
  );

  modport master (
    output req0, req1, op0, op1, amt0, amt1, dir0, dir1, sh_result,
    input  ack0, ack1, done0, done1, res, sh_a, sh_amt, sh_dir, busy, op_count
  );
endinterface

// File: rtl/shift_arbiter.sv
// Two-port round-robin arbiter in front of a shared combinational shifter.
// One operation takes three cycles: IDLE (grant/latch) -> ISSUE (ack,
// drive shifter) -> RESP (done, res valid).
// Ports:
//   clock  : rising-edge clock
//   resetn : asynchronous active-low reset
//   bus    : shift_arbiter_if.slave (requests, operands, acks, dones, res,
//            shifter link, busy, saturating op_count)
module shift_arbiter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic          clock,
  input  logic          resetn,
  shift_arbiter_if.slave bus
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned AMT_W  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               rr_q, rr_d;
  logic               id_q, id_d;
  logic [DATA_W-1:0]  sh_a_q, sh_a_d;
  logic [AMT_W-1:0]   sh_amt_q, sh_amt_d;
  logic               sh_dir_q, sh_dir_d;
  logic               ack0_q, ack0_d;
  logic               ack1_q, ack1_d;
  logic               done0_q, done0_d;
  logic               done1_q, done1_d;
  logic [DATA_W-1:0]  res_q, res_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               grant;

  // State and output registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      rr_q     <= 1'b0;
      id_q     <= 1'b0;
      sh_a_q   <= '0;
      sh_amt_q <= '0;
      sh_dir_q <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      res_q    <= '0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      id_q     <= id_d;
      sh_a_q   <= sh_a_d;
      sh_amt_q <= sh_amt_d;
      sh_dir_q <= sh_dir_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      res_q    <= res_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state and next-output logic. The shifter operand registers double
  // as the operand latch: loaded on the grant edge, zero outside ISSUE.
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    id_d     = id_q;
    sh_a_d   = '0;
    sh_amt_d = '0;
    sh_dir_d = 1'b0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    res_d    = res_q;
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    grant    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          // Contention resolved by the pointer; otherwise the lone requester
          grant    = (bus.req0 && bus.req1) ? rr_q : bus.req1;
          state_d  = ISSUE;
          id_d     = grant;
          rr_d     = ~grant;
          sh_a_d   = grant ? bus.op1  : bus.op0;
          sh_amt_d = grant ? bus.amt1 : bus.amt0;
          sh_dir_d = grant ? bus.dir1 : bus.dir0;
          ack0_d   = ~grant;
          ack1_d   = grant;
          busy_d   = 1'b1;
        end
      end
      ISSUE: begin
        state_d = RESP;
        res_d   = bus.sh_result;
        done0_d = ~id_q;
        done1_d = id_q;
        busy_d  = 1'b1;
      end
      RESP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.ack0     = ack0_q;
  assign bus.ack1     = ack1_q;
  assign bus.done0    = done0_q;
  assign bus.done1    = done1_q;
  assign bus.res      = res_q;
  assign bus.sh_a     = sh_a_q;
  assign bus.sh_amt   = sh_amt_q;
  assign bus.sh_dir   = sh_dir_q;
  assign bus.busy     = busy_q;
  assign bus.op_count = cnt_q;

endmodule

// File: tb/tb_shift_arbiter.sv
module tb_shift_arbiter;

  logic clock;
  logic resetn;

  shift_arbiter_if #(.CNT_W(16)) bus ();
  shift_arbiter_if #(.CNT_W(2))  bus2 ();

  shift_arbiter #(.CNT_W(16)) dut  (.clock(clock), .resetn(resetn), .bus(bus));
  shift_arbiter #(.CNT_W(2))  dut2 (.clock(clock), .resetn(resetn), .bus(bus2));

  // External shared shifters
  assign bus.sh_result  = bus.sh_dir  ? 32'($signed(bus.sh_a)  >>> bus.sh_amt)  : (bus.sh_a  << bus.sh_amt);
  assign bus2.sh_result = bus2.sh_dir ? 32'($signed(bus2.sh_a) >>> bus2.sh_amt) : (bus2.sh_a << bus2.sh_amt);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp;
  int n_err;
  int exp_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        req0;
    logic [31:0] op0;
    logic [4:0]  amt0;
    logic        dir0;
    logic        req1;
    logic [31:0] op1;
    logic [4:0]  amt1;
    logic        dir1;
    logic        exp_id;
    logic [31:0] exp_res;
  } vec_t;

  vec_t vecs[7];

  logic [3:0] exp_pat[9];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    exp_cnt = 0;

    //        req0 op0           amt dir  req1 op1           amt dir  id  res
    vecs[0] = '{1'b1, 32'h0000_0001, 5'd4,  1'b0, 1'b0, 32'h0,         5'd0,  1'b0, 1'b0, 32'h0000_0010};
    vecs[1] = '{1'b0, 32'h0,         5'd0,  1'b0, 1'b1, 32'h8000_0000, 5'd31, 1'b1, 1'b1, 32'hFFFF_FFFF};
    vecs[2] = '{1'b0, 32'h0,         5'd0,  1'b0, 1'b1, 32'h8000_0000, 5'd0,  1'b1, 1'b1, 32'h8000_0000};
    vecs[3] = '{1'b1, 32'h0000_00F0, 5'd4,  1'b1, 1'b1, 32'h0000_0001, 5'd31, 1'b0, 1'b0, 32'h0000_000F};
    vecs[4] = '{1'b1, 32'h1234_5678, 5'd8,  1'b0, 1'b1, 32'hFFFF_0000, 5'd16, 1'b1, 1'b1, 32'hFFFF_FFFF};
    vecs[5] = '{1'b1, 32'h1234_5678, 5'd8,  1'b0, 1'b0, 32'h0,         5'd0,  1'b0, 1'b0, 32'h3456_7800};
    vecs[6] = '{1'b1, 32'h8000_0001, 5'd1,  1'b0, 1'b0, 32'h0,         5'd0,  1'b0, 1'b0, 32'h0000_0002};

    // {ack0, ack1, done0, done1} per cycle with both requests held
    exp_pat[0] = 4'b1000; exp_pat[1] = 4'b0010; exp_pat[2] = 4'b0000;
    exp_pat[3] = 4'b0100; exp_pat[4] = 4'b0001; exp_pat[5] = 4'b0000;
    exp_pat[6] = 4'b1000; exp_pat[7] = 4'b0010; exp_pat[8] = 4'b0000;

    resetn   = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.op0  = '0;   bus.op1  = '0;
    bus.amt0 = '0;   bus.amt1 = '0;
    bus.dir0 = 1'b0; bus.dir1 = 1'b0;
    bus2.req0 = 1'b0; bus2.req1 = 1'b0;
    bus2.op0  = 32'h0000_0003; bus2.op1 = '0;
    bus2.amt0 = 5'd1; bus2.amt1 = '0;
    bus2.dir0 = 1'b0; bus2.dir1 = 1'b0;

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_ack", {30'd0, bus.ack1, bus.ack0}, 32'd0);
    check("rst_done", {30'd0, bus.done1, bus.done0}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_res", bus.res, 32'd0);
    check("rst_sh", {bus.sh_a[26:0], bus.sh_amt}, 32'd0);
    check("rst_sh_dir", {31'd0, bus.sh_dir}, 32'd0);
    check("rst_cnt", 32'(bus.op_count), 32'd0);
    resetn = 1'b1;

    // Table-driven single operations
    for (int i = 0; i < 7; i++) begin
      bus.req0 = vecs[i].req0; bus.op0 = vecs[i].op0; bus.amt0 = vecs[i].amt0; bus.dir0 = vecs[i].dir0;
      bus.req1 = vecs[i].req1; bus.op1 = vecs[i].op1; bus.amt1 = vecs[i].amt1; bus.dir1 = vecs[i].dir1;
      @(negedge clock);
      check($sformatf("v%0d_ack0", i), {31'd0, bus.ack0}, {31'd0, ~vecs[i].exp_id});
      check($sformatf("v%0d_ack1", i), {31'd0, bus.ack1}, {31'd0, vecs[i].exp_id});
      check($sformatf("v%0d_busy", i), {31'd0, bus.busy}, 32'd1);
      check($sformatf("v%0d_sh_a", i), bus.sh_a, vecs[i].exp_id ? vecs[i].op1 : vecs[i].op0);
      check($sformatf("v%0d_sh_amt", i), {27'd0, bus.sh_amt}, {27'd0, vecs[i].exp_id ? vecs[i].amt1 : vecs[i].amt0});
      // Scramble operands after the latch edge
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      bus.op0 = 32'hDEAD_BEEF; bus.op1 = 32'hCAFE_F00D; bus.amt0 = 5'd7; bus.amt1 = 5'd3;
      @(negedge clock);
      check($sformatf("v%0d_done0", i), {31'd0, bus.done0}, {31'd0, ~vecs[i].exp_id});
      check($sformatf("v%0d_done1", i), {31'd0, bus.done1}, {31'd0, vecs[i].exp_id});
      check($sformatf("v%0d_res", i), bus.res, vecs[i].exp_res);
      check($sformatf("v%0d_sh_idle", i), bus.sh_a, 32'd0);
      @(negedge clock);
      exp_cnt++;
      check($sformatf("v%0d_cnt", i), 32'(bus.op_count), 32'(exp_cnt));
      check($sformatf("v%0d_busy_end", i), {31'd0, bus.busy}, 32'd0);
      check($sformatf("v%0d_res_hold", i), bus.res, vecs[i].exp_res);
    end

    // Late request during ISSUE waits for the next IDLE
    bus.req0 = 1'b1; bus.op0 = 32'h0000_00FF; bus.amt0 = 5'd4; bus.dir0 = 1'b0;
    @(negedge clock);
    check("stab_ack0", {31'd0, bus.ack0}, 32'd1);
    bus.req0 = 1'b0; bus.op0 = 32'hFFFF_FFFF;
    bus.req1 = 1'b1; bus.op1 = 32'h0000_0003; bus.amt1 = 5'd1; bus.dir1 = 1'b0;
    @(negedge clock);
    check("stab_done0", {31'd0, bus.done0}, 32'd1);
    check("stab_res0", bus.res, 32'h0000_0FF0);
    check("stab_no_ack1_resp", {31'd0, bus.ack1}, 32'd0);
    @(negedge clock);
    exp_cnt++;
    check("stab_no_ack1_idle", {31'd0, bus.ack1}, 32'd0);
    check("stab_idle_busy", {31'd0, bus.busy}, 32'd0);
    check("stab_cnt0", 32'(bus.op_count), 32'(exp_cnt));
    @(negedge clock);
    check("stab_ack1", {31'd0, bus.ack1}, 32'd1);
    bus.req1 = 1'b0;
    @(negedge clock);
    check("stab_done1", {31'd0, bus.done1}, 32'd1);
    check("stab_res1", bus.res, 32'h0000_0006);
    @(negedge clock);
    exp_cnt++;
    check("stab_cnt1", 32'(bus.op_count), 32'(exp_cnt));

    // Reset during ISSUE aborts the operation
    bus.req0 = 1'b1; bus.op0 = 32'h0000_0005; bus.amt0 = 5'd1; bus.dir0 = 1'b0;
    @(negedge clock);
    check("abort_ack0", {31'd0, bus.ack0}, 32'd1);
    bus.req0 = 1'b0;
    resetn = 1'b0;
    #1;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_res", bus.res, 32'd0);
    check("abort_sh_a", bus.sh_a, 32'd0);
    check("abort_ack0_clr", {31'd0, bus.ack0}, 32'd0);
    check("abort_cnt", 32'(bus.op_count), 32'd0);
    exp_cnt = 0;
    @(negedge clock);
    resetn = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      check($sformatf("abort_no_done_%0d", k), {30'd0, bus.done1, bus.done0}, 32'd0);
      check($sformatf("abort_cnt_%0d", k), 32'(bus.op_count), 32'd0);
    end

    // Both requests held from reset: 0, 1, 0 ...
    resetn = 1'b0;
    bus.req0 = 1'b1; bus.op0 = 32'h0000_0001; bus.amt0 = 5'd1; bus.dir0 = 1'b0;
    bus.req1 = 1'b1; bus.op1 = 32'h4000_0000; bus.amt1 = 5'd2; bus.dir1 = 1'b1;
    @(negedge clock);
    resetn = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clock);
      check($sformatf("rr_pat_%0d", k), {28'd0, bus.ack0, bus.ack1, bus.done0, bus.done1}, {28'd0, exp_pat[k]});
      if (k == 1) check("rr_res0", bus.res, 32'h0000_0002);
      if (k == 4) check("rr_res1", bus.res, 32'h1000_0000);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (3) @(negedge clock);
    check("rr_cnt", 32'(bus.op_count), 32'd3);

    // Saturating counter on the narrow instance
    bus2.req0 = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      repeat (3) @(negedge clock);
      check($sformatf("sat_cnt_%0d", k), 32'(bus2.op_count), (k > 3) ? 32'd3 : 32'(k));
    end
    bus2.req0 = 1'b0;
    check("sat_res", bus2.res, 32'h0000_0006);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
